// File: rtl/core_pkg.sv
// Shared definitions for the MEM stage: access-size codes, FSM states,
// the latched access context and the alignment rule.
package core_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;
    localparam int unsigned F3_W_ = 3;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    // Everything needed at completion time, captured when the access issues.
    typedef struct packed {
        logic [F3_W_-1:0] funct3;
        logic [1:0]       addr_lo;
        logic [REG_W-1:0] rd;
        logic             memtoreg;
        logic             regwrite;
        logic             we;
        logic [XLEN-1:0]  alu;
    } mem_ctx_t;

    // Unknown size codes count as misaligned so they never reach memory.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad;
        case (funct3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = addr_lo[0];
            F3_W:        bad = (addr_lo != 2'b00);
            default:     bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store data/byte enables out, load data extraction and
// sign/zero extension in.
module mem_lane_align
    import core_pkg::*;
(
    input  logic [2:0]      st_funct3,
    input  logic [1:0]      st_addr,
    input  logic [XLEN-1:0] st_data,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata,
    input  logic [2:0]      ld_funct3,
    input  logic [1:0]      ld_addr,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] load_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Replicate narrow store data into every lane; the mask picks the live one.
    always_comb begin
        be    = 4'b0000;
        wdata = st_data;
        case (st_funct3)
            F3_B, F3_BU: begin
                be    = 4'b0001 << st_addr;
                wdata = {4{st_data[7:0]}};
            end
            F3_H, F3_HU: begin
                be    = 4'b0011 << st_addr;
                wdata = {2{st_data[15:0]}};
            end
            F3_W:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    always_comb begin
        ld_byte   = 8'h00;
        ld_half   = ld_addr[1] ? rdata[31:16] : rdata[15:0];
        load_data = '0;
        case (ld_addr)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        case (ld_funct3)
            F3_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
            F3_BU:   load_data = {24'd0, ld_byte};
            F3_H:    load_data = {{16{ld_half[15]}}, ld_half};
            F3_HU:   load_data = {16'd0, ld_half};
            F3_W:    load_data = rdata;
            default: load_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: branch resolve, handshaked data-memory access with
// timeout, upstream stall and MEM/WB register.
module mem_access_stage
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Ctl_MemtoReg_in,
    input  logic             Ctl_RegWrite_in,
    input  logic             Ctl_MemRead_in,
    input  logic             Ctl_MemWrite_in,
    input  logic             Ctl_Branch_in,
    input  logic             Zero_in,
    input  logic [4:0]       Rd_in,
    input  logic [2:0]       funct3_in,
    input  logic [31:0]      ALUresult_in,
    input  logic [31:0]      PCimm_in,
    input  logic [31:0]      ReadData2_in,
    output logic             PCSrc_out,
    output logic [31:0]      PCimm_out,
    output logic             stall_out,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wdata,
    output logic [3:0]       dmem_be,
    input  logic             dmem_ready,
    input  logic [31:0]      dmem_rdata,
    output logic             Ctl_MemtoReg_out,
    output logic             Ctl_RegWrite_out,
    output logic [4:0]       Rd_out,
    output logic [31:0]      ALUresult_out,
    output logic [31:0]      ReadData_out,
    output logic             err_out
);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    mem_ctx_t         ctx, ctx_d;

    logic        req_d, we_d;
    logic [31:0] addr_d, wdata_d;
    logic [3:0]  be_d;
    logic        memtoreg_d, regwrite_d, err_d;
    logic [4:0]  rd_d;
    logic [31:0] alu_d, rdata_d;

    logic        mem_op, bad_align, timeout_hit;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_data;

    assign PCSrc_out   = Ctl_Branch_in & Zero_in;
    assign PCimm_out   = PCimm_in;
    assign mem_op      = Ctl_MemRead_in | Ctl_MemWrite_in;
    assign bad_align   = misaligned(funct3_in, ALUresult_in[1:0]);
    assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    mem_lane_align u_align (
        .st_funct3 (funct3_in),
        .st_addr   (ALUresult_in[1:0]),
        .st_data   (ReadData2_in),
        .be        (st_be),
        .wdata     (st_wdata),
        .ld_funct3 (ctx.funct3),
        .ld_addr   (ctx.addr_lo),
        .rdata     (dmem_rdata),
        .load_data (ld_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            ctx              <= '0;
            dmem_req         <= 1'b0;
            dmem_we          <= 1'b0;
            dmem_addr        <= '0;
            dmem_wdata       <= '0;
            dmem_be          <= '0;
            Ctl_MemtoReg_out <= 1'b0;
            Ctl_RegWrite_out <= 1'b0;
            Rd_out           <= '0;
            ALUresult_out    <= '0;
            ReadData_out     <= '0;
            err_out          <= 1'b0;
        end else begin
            state            <= state_d;
            cnt              <= cnt_d;
            ctx              <= ctx_d;
            dmem_req         <= req_d;
            dmem_we          <= we_d;
            dmem_addr        <= addr_d;
            dmem_wdata       <= wdata_d;
            dmem_be          <= be_d;
            Ctl_MemtoReg_out <= memtoreg_d;
            Ctl_RegWrite_out <= regwrite_d;
            Rd_out           <= rd_d;
            ALUresult_out    <= alu_d;
            ReadData_out     <= rdata_d;
            err_out          <= err_d;
        end
    end

    // Next state, memory port, MEM/WB payload; MEM/WB defaults to a bubble.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        ctx_d      = ctx;
        req_d      = dmem_req;
        we_d       = dmem_we;
        addr_d     = dmem_addr;
        wdata_d    = dmem_wdata;
        be_d       = dmem_be;
        memtoreg_d = 1'b0;
        regwrite_d = 1'b0;
        rd_d       = '0;
        alu_d      = '0;
        rdata_d    = '0;
        err_d      = 1'b0;
        stall_out  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!mem_op) begin
                    memtoreg_d = Ctl_MemtoReg_in;
                    regwrite_d = Ctl_RegWrite_in;
                    rd_d       = Rd_in;
                    alu_d      = ALUresult_in;
                end else if (bad_align) begin
                    err_d = 1'b1;
                end else begin
                    stall_out = 1'b1;
                    state_d   = ST_ACCESS;
                    cnt_d     = '0;
                    req_d     = 1'b1;
                    // Read+write together is illegal: perform the read, flag it.
                    we_d      = Ctl_MemWrite_in & ~Ctl_MemRead_in;
                    err_d     = Ctl_MemWrite_in & Ctl_MemRead_in;
                    addr_d    = {ALUresult_in[31:2], 2'b00};
                    be_d      = st_be;
                    wdata_d   = st_wdata;
                    ctx_d     = '{funct3:   funct3_in,
                                  addr_lo:  ALUresult_in[1:0],
                                  rd:       Rd_in,
                                  memtoreg: Ctl_MemtoReg_in,
                                  regwrite: Ctl_RegWrite_in,
                                  we:       Ctl_MemWrite_in & ~Ctl_MemRead_in,
                                  alu:      ALUresult_in};
                end
            end
            ST_ACCESS: begin
                if (dmem_ready) begin
                    state_d    = ST_IDLE;
                    req_d      = 1'b0;
                    we_d       = 1'b0;
                    memtoreg_d = ctx.memtoreg;
                    regwrite_d = ctx.regwrite;
                    rd_d       = ctx.rd;
                    alu_d      = ctx.alu;
                    rdata_d    = ctx.we ? 32'd0 : ld_data;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    stall_out = 1'b1;
                    cnt_d     = cnt + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
